// File: rtl/move_scheduler.sv
// move_scheduler: turns gravity ticks and player button edges into a stream
// of single board operations and hands them to the board datapath through a
// valid/ready offer followed by a done/blocked completion pulse.
//
// Build option: define SOFT_DROP_EN to add the soft_drop port. While soft_drop
// is held, the gravity period is clamped to SOFT_PERIOD, and a soft_drop
// rising edge restarts the gravity count.
//
// Ports
//   clock, reset      clock; asynchronous active-high reset
//   enable            game controller is in its drop-block state
//   move_left/right,  level-held player buttons (already synchronised)
//   rotate
//   soft_drop         held soft-drop button (SOFT_DROP_EN builds only)
//   level[3:0]        game level 0..15, sets the gravity period
//   op_valid/op_code  operation offered: 00 down, 01 left, 10 right, 11 rotate
//   op_ready          datapath accepts the offer
//   op_done           one-cycle completion pulse from the datapath
//   op_blocked        qualifies op_done: the move was illegal and not applied
//   filled_under      one-cycle pulse: a down move was blocked (piece lands)
//   busy              an operation is offered or in flight
module move_scheduler #(
  parameter logic [25:0] PERIOD_BASE = 26'd50_000_000,
  parameter logic [25:0] PERIOD_STEP = 26'd4_000_000,
  parameter logic [25:0] PERIOD_MIN  = 26'd5_000_000,
  parameter logic [25:0] SOFT_PERIOD = 26'd2_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       rotate,
`ifdef SOFT_DROP_EN
  input  logic       soft_drop,
`endif
  input  logic [3:0] level,
  output logic       op_valid,
  output logic [1:0] op_code,
  input  logic       op_ready,
  input  logic       op_done,
  input  logic       op_blocked,
  output logic       filled_under,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LOCKED} state_t;

  localparam logic [1:0] OP_DOWN  = 2'b00;
  localparam logic [1:0] OP_LEFT  = 2'b01;
  localparam logic [1:0] OP_RIGHT = 2'b10;
  localparam logic [1:0] OP_ROT   = 2'b11;

  localparam logic [29:0] BASE30 = 30'(PERIOD_BASE);
  localparam logic [29:0] STEP30 = 30'(PERIOD_STEP);
  localparam logic [29:0] MIN30  = 30'(PERIOD_MIN);

  state_t      state_q, state_d;
  logic [25:0] counter;
  logic [25:0] period;
  logic [29:0] step_prod, diff;
  logic        grav_p, rot_p, left_p, right_p;
  logic        count_en, tick, issue, clear_all, lock_evt;
  logic        l_edge, r_edge, left_eff, right_eff;
  logic        sel_grav, sel_rot, sel_left, sel_right;
  logic [1:0]  sel_code;
  logic [2:0]  btn, btn_q, btn_edge;
  logic        armed;
  logic        soft_edge;

  // ---------------------------------------------------------------- buttons
  // armed stays low for the first clock after reset so that a button held
  // across reset release loads btn_q without being seen as a rising edge.
  assign btn      = {rotate, move_right, move_left};
  assign btn_edge = armed ? (btn & ~btn_q) : 3'b000;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_q <= 3'b000;
      armed <= 1'b0;
    end else begin
      btn_q <= btn;
      armed <= 1'b1;
    end
  end

`ifdef SOFT_DROP_EN
  logic soft_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) soft_q <= 1'b0;
    else       soft_q <= soft_drop;
  end
  assign soft_edge = armed & soft_drop & ~soft_q;
`else
  assign soft_edge = 1'b0;
`endif

  // Opposing lateral edges in one cycle cancel; a lone edge wins over a
  // pending opposite flag, and that flag is masked from selection in the
  // same cycle so the stale direction is never issued.
  assign l_edge    = enable & btn_edge[0] & ~btn_edge[1];
  assign r_edge    = enable & btn_edge[1] & ~btn_edge[0];
  assign left_eff  = left_p  & ~r_edge;
  assign right_eff = right_p & ~l_edge;

  // ----------------------------------------------------------------- period
  // Underflow of the level subtraction and results under the floor both
  // land on PERIOD_MIN.
  always_comb begin
    step_prod = 30'(level) * STEP30;
    diff      = 30'd0;
    if (step_prod > BASE30) begin
      period = PERIOD_MIN;
    end else begin
      diff   = BASE30 - step_prod;
      period = (diff < MIN30) ? PERIOD_MIN : diff[25:0];
    end
`ifdef SOFT_DROP_EN
    if (soft_drop && (SOFT_PERIOD < period)) period = SOFT_PERIOD;
`endif
  end

  // ---------------------------------------------------------------- gravity
  // '>=' rather than '==' so a level change that shortens the period below
  // the current count fires at once instead of running to wrap-around.
  assign count_en = enable && (state_q != LOCKED);
  assign tick     = count_en && (counter >= period - 26'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      counter <= 26'd0;
    else if (!count_en || soft_edge) counter <= 26'd0;
    else if (tick)                  counter <= 26'd0;
    else                            counter <= counter + 26'd1;
  end

  // -------------------------------------------------------------- selection
  assign sel_grav  = grav_p;
  assign sel_rot   = !grav_p && rot_p;
  assign sel_left  = !grav_p && !rot_p && left_eff;
  assign sel_right = !grav_p && !rot_p && !left_eff && right_eff;
  assign issue     = (state_q == IDLE) && enable &&
                     (grav_p || rot_p || left_eff || right_eff);

  always_comb begin
    sel_code = OP_RIGHT;
    if (sel_grav)      sel_code = OP_DOWN;
    else if (sel_rot)  sel_code = OP_ROT;
    else if (sel_left) sel_code = OP_LEFT;
  end

  // Flags are dropped whenever enable is low outside a handshake, and on the
  // completion of a handshake that finished after enable fell.
  assign clear_all = !enable && ((state_q == IDLE) || (state_q == LOCKED) ||
                                 ((state_q == WAIT) && op_done));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grav_p  <= 1'b0;
      rot_p   <= 1'b0;
      left_p  <= 1'b0;
      right_p <= 1'b0;
    end else if (clear_all) begin
      grav_p  <= 1'b0;
      rot_p   <= 1'b0;
      left_p  <= 1'b0;
      right_p <= 1'b0;
    end else begin
      // A tick landing on an already pending gravity request is dropped.
      grav_p  <= issue && sel_grav ? 1'b0 : (grav_p | tick);
      rot_p   <= (rot_p & ~(issue && sel_rot)) | (enable & btn_edge[2]);
      left_p  <= (left_p & ~(issue && sel_left) & ~r_edge) | l_edge;
      right_p <= (right_p & ~(issue && sel_right) & ~l_edge) | r_edge;
    end
  end

  // -------------------------------------------------------------------- fsm
  assign lock_evt = (state_q == WAIT) && op_done && (op_code == OP_DOWN) && op_blocked;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_code      <= OP_DOWN;
      filled_under <= 1'b0;
    end else begin
      state_q      <= state_d;
      filled_under <= lock_evt;
      if (issue) op_code <= sel_code;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_valid = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE:   if (issue) state_d = ISSUE;
      ISSUE: begin
        op_valid = 1'b1;
        busy     = 1'b1;
        if (op_ready) state_d = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (op_done) state_d = lock_evt ? LOCKED : IDLE;
      end
      LOCKED: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with a small period set
// (base 10, step 2, floor 4, soft 3). A datapath model accepts every offer
// and returns op_done 'lat' cycles after the accept cycle (2 by default).
// Every offered op is logged with its cycle number; the checks compare that
// log against hand-computed cycle numbers and codes.
module tb_move_scheduler;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       move_left = 1'b0, move_right = 1'b0, rotate = 1'b0;
`ifdef SOFT_DROP_EN
  logic       soft_drop = 1'b0;
`endif
  logic [3:0] level = 4'd0;
  logic       op_valid;
  logic [1:0] op_code;
  logic       op_ready = 1'b1;
  logic       op_done = 1'b0, op_blocked = 1'b0;
  logic       filled_under, busy;

  int         checks = 0, errors = 0;
  int         cyc = 0;
  int         log_cyc[$];
  logic [1:0] log_code[$];
  int         fcnt = 0;
  int         lat = 2, rsp_cnt = 0;
  logic [1:0] rsp_code = 2'b00;
  logic       block_down = 1'b0;
  int         base, c, e, r, fc0;

  move_scheduler #(
    .PERIOD_BASE(26'd10), .PERIOD_STEP(26'd2),
    .PERIOD_MIN(26'd4),   .SOFT_PERIOD(26'd3)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .move_left(move_left), .move_right(move_right), .rotate(rotate),
`ifdef SOFT_DROP_EN
    .soft_drop(soft_drop),
`endif
    .level(level), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .op_done(op_done), .op_blocked(op_blocked),
    .filled_under(filled_under), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Op log and filled_under pulse counter, sampled mid-cycle.
  always @(negedge clock) begin
    if (op_valid && op_ready) begin
      log_cyc.push_back(cyc);
      log_code.push_back(op_code);
    end
    if (filled_under) fcnt <= fcnt + 1;
  end

  // Datapath model: op_done in the cycle 'lat' after the accept cycle.
  always @(negedge clock) begin
    if (reset) begin
      rsp_cnt    <= 0;
      op_done    <= 1'b0;
      op_blocked <= 1'b0;
    end else begin
      op_done    <= (rsp_cnt == 1);
      op_blocked <= (rsp_cnt == 1) && block_down && (rsp_code == 2'b00);
      if (op_valid && op_ready) begin
        rsp_cnt  <= lat;
        rsp_code <= op_code;
      end else if (rsp_cnt > 0) begin
        rsp_cnt <= rsp_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #2;
    end
  endtask

  task automatic wait_ops(input string tag, input int target, input int budget);
    int b;
    b = budget;
    while (log_cyc.size() < target && b > 0) begin
      step(1);
      b--;
    end
    check({tag, "_timeout"}, 32'(log_cyc.size() >= target), 32'd1);
  endtask

  function automatic int lc(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -1000;
  endfunction

  function automatic logic [1:0] lcode(input int i);
    return (i < log_code.size()) ? log_code[i] : 2'bxx;
  endfunction

  function automatic int count_lat(input int from);
    int n;
    n = 0;
    for (int i = from; i < log_code.size(); i++)
      if (log_code[i] == 2'b01 || log_code[i] == 2'b10) n++;
    return n;
  endfunction

  function automatic logic [1:0] last_lat(input int from);
    logic [1:0] v;
    v = 2'b00;
    for (int i = from; i < log_code.size(); i++)
      if (log_code[i] == 2'b01 || log_code[i] == 2'b10) v = log_code[i];
    return v;
  endfunction

  // Enable rises in cycle e; count reaches P-1 at cycle e+P-1, the flag is
  // visible at e+P and the down op is offered at e+P+1, then every P cycles.
  task automatic run_grav(input logic [3:0] lv, input int p, input string tag);
    int b0, e0;
    enable = 1'b0;
    step(4);
    level  = lv;
    b0     = log_cyc.size();
    enable = 1'b1;
    e0     = cyc;
    wait_ops(tag, b0 + 3, 3 * p + 20);
    check({tag, "_first"}, lc(b0), e0 + p + 1);
    check({tag, "_gap1"}, lc(b0 + 1) - lc(b0), p);
    check({tag, "_gap2"}, lc(b0 + 2) - lc(b0 + 1), p);
    check({tag, "_code"}, lcode(b0 + 2), 2'b00);
  endtask

  initial begin
    // Reset state.
    step(2);
    check("rst_op_valid", op_valid, 0);
    check("rst_op_code", op_code, 0);
    check("rst_busy", busy, 0);
    check("rst_filled", filled_under, 0);
    reset = 1'b0;
    step(2);

    // Gravity spacing: level 0 -> 10, level 3 -> 4, level 9 (underflow) -> 4.
    run_grav(4'd0, 10, "grav_l0");
    run_grav(4'd3, 4, "grav_l3");
    run_grav(4'd9, 4, "grav_l9");

    // Rotate + left edges in the cycle of a gravity tick (tick at c+8).
    enable = 1'b0;
    step(4);
    level  = 4'd0;
    base   = log_cyc.size();
    enable = 1'b1;
    wait_ops("prio_sync", base + 1, 20);
    c = lc(base);
    step(c + 8 - cyc);
    rotate    = 1'b1;
    move_left = 1'b1;
    wait_ops("prio", base + 4, 40);
    check("prio_code0", lcode(base + 1), 2'b00);
    check("prio_code1", lcode(base + 2), 2'b11);
    check("prio_code2", lcode(base + 3), 2'b01);
    check("prio_cyc0", lc(base + 1), c + 10);
    check("prio_cyc1", lc(base + 2), c + 14);
    check("prio_cyc2", lc(base + 3), c + 18);
    rotate    = 1'b0;
    move_left = 1'b0;
    step(3);

    // Left and right together: nothing lateral issued.
    base       = log_cyc.size();
    move_left  = 1'b1;
    move_right = 1'b1;
    step(12);
    check("lr_same_none", count_lat(base), 0);
    move_left  = 1'b0;
    move_right = 1'b0;
    step(2);
    // Left, then right one cycle later: a single right op.
    base      = log_cyc.size();
    move_left = 1'b1;
    step(1);
    move_right = 1'b1;
    step(14);
    check("lr_seq_count", count_lat(base), 1);
    check("lr_seq_code", last_lat(base), 2'b10);
    move_left  = 1'b0;
    move_right = 1'b0;
    step(2);

    // Blocked down op: one filled_under pulse, then locked until enable cycles.
    block_down = 1'b1;
    base       = log_cyc.size();
    fc0        = fcnt;
    wait_ops("lock", base + 1, 30);
    check("lock_code", lcode(base), 2'b00);
    step(5);
    block_down = 1'b0;
    check("lock_pulse", fcnt - fc0, 1);
    check("lock_busy", busy, 0);
    check("lock_valid", op_valid, 0);
    step(25);
    check("lock_no_ops", log_cyc.size(), base + 1);
    check("lock_pulse_once", fcnt - fc0, 1);
    enable = 1'b0;
    step(2);
    enable = 1'b1;
    e      = cyc;
    wait_ops("unlock", base + 2, 20);
    check("unlock_first", lc(base + 1), e + 11);

    // Reset while an op is offered; rotate held through release gives no op.
    begin
      int b;
      b = 40;
      while (!op_valid && b > 0) begin
        step(1);
        b--;
      end
    end
    check("rst_mid_seen_valid", op_valid, 1);
    reset  = 1'b1;
    rotate = 1'b1;
    #1;
    check("rst_mid_valid", op_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_code", op_code, 0);
    check("rst_mid_filled", filled_under, 0);
    step(1);
    reset = 1'b0;
    r     = cyc;
    base  = log_cyc.size();
    step(10);
    check("rst_no_early_op", log_cyc.size(), base);
    wait_ops("rst_after", base + 1, 10);
    check("rst_after_cyc", lc(base), r + 11);
    check("rst_after_code", lcode(base), 2'b00);
    rotate = 1'b0;

`ifdef SOFT_DROP_EN
    // A 3-cycle period can only be kept up when op_done comes back on the
    // first cycle after acceptance.
    lat    = 1;
    enable = 1'b0;
    step(4);
    level     = 4'd0;
    soft_drop = 1'b1;
    enable    = 1'b1;
    step(12);
    base = log_cyc.size();
    wait_ops("soft", base + 3, 20);
    check("soft_gap1", lc(base + 1) - lc(base), 3);
    check("soft_gap2", lc(base + 2) - lc(base + 1), 3);
    soft_drop = 1'b0;
    step(15);
    base = log_cyc.size();
    wait_ops("soft_rel", base + 3, 40);
    check("soft_rel_gap1", lc(base + 1) - lc(base), 10);
    check("soft_rel_gap2", lc(base + 2) - lc(base + 1), 10);
    lat = 2;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
